// File: rtl/vga_pkg.sv
// Frame-buffer geometry, pixel format and writer state encoding shared by
// the spectrum writer and the VGA scan-out.
package vga_pkg;
  localparam int FB_WIDTH   = 320;
  localparam int FB_HEIGHT  = 240;
  localparam int DEPTH      = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_WIDTH = 17;
  localparam int DATA_WIDTH = 12;
  localparam int H_W        = 9;

  localparam logic [DATA_WIDTH-1:0] BAR_COLOR = 12'h0F0;
  localparam logic [DATA_WIDTH-1:0] BG_COLOR  = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } fb_state_e;
endpackage

// File: rtl/fb_column_addr_gen.sv
// Column-major pixel walker: y inside a column, then column/x, with the
// linear address kept as a running sum so no multiplier is needed.
module fb_column_addr_gen #(
  parameter int FB_WIDTH   = vga_pkg::FB_WIDTH,
  parameter int FB_HEIGHT  = vga_pkg::FB_HEIGHT,
  parameter int BAR_WIDTH  = 5,
  parameter int ADDR_WIDTH = vga_pkg::ADDR_WIDTH,
  parameter int XW         = $clog2(FB_WIDTH + 1),
  parameter int YW         = $clog2(FB_HEIGHT),
  parameter int CW         = $clog2(BAR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_load_col,
  input  logic                  i_advance,
  output logic [YW-1:0]         o_y_nxt,
  output logic [CW-1:0]         o_col_nxt,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_y_last,
  output logic                  o_col_last
);
  logic [XW-1:0]         r_x, w_x_nxt;
  logic [YW-1:0]         r_y, w_y_nxt;
  logic [CW-1:0]         r_col, w_col_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;

  assign o_y_last   = (r_y == YW'(FB_HEIGHT - 1));
  assign o_col_last = (r_col == CW'(BAR_WIDTH - 1));
  assign o_y_nxt    = w_y_nxt;
  assign o_col_nxt  = w_col_nxt;
  assign o_addr     = r_addr;

  // x only moves at a column change, so it already holds the next bar's
  // first column when a new bar is loaded.
  always_comb begin
    w_x_nxt    = r_x;
    w_y_nxt    = r_y;
    w_col_nxt  = r_col;
    w_addr_nxt = r_addr;
    if (i_clear) begin
      w_x_nxt    = '0;
      w_y_nxt    = '0;
      w_col_nxt  = '0;
      w_addr_nxt = '0;
    end else if (i_load_col) begin
      w_y_nxt    = '0;
      w_col_nxt  = '0;
      w_addr_nxt = ADDR_WIDTH'(r_x);
    end else if (i_advance) begin
      if (!o_y_last) begin
        w_y_nxt    = r_y + 1'b1;
        w_addr_nxt = r_addr + ADDR_WIDTH'(FB_WIDTH);
      end else begin
        w_y_nxt    = '0;
        w_x_nxt    = r_x + 1'b1;
        w_addr_nxt = ADDR_WIDTH'(r_x) + 1'b1;
        w_col_nxt  = o_col_last ? '0 : r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_col  <= w_col_nxt;
      r_addr <= w_addr_nxt;
    end
  end
endmodule

// File: rtl/spectrum_fb_writer.sv
// Renders one frame of spectrum bars into the frame buffer: fetch a bin
// magnitude, then paint its bar column by column, one pixel per clock.
module spectrum_fb_writer #(
  parameter int ADDR_WIDTH = vga_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = vga_pkg::DATA_WIDTH,
  parameter int FB_WIDTH   = vga_pkg::FB_WIDTH,
  parameter int FB_HEIGHT  = vga_pkg::FB_HEIGHT,
  parameter int NUM_BINS   = 64,
  parameter int BAR_WIDTH  = 5,
  parameter int MAG_WIDTH  = 16,
  parameter int MAG_SHIFT  = 4,
  parameter logic [DATA_WIDTH-1:0] BAR_COLOR = vga_pkg::BAR_COLOR,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR  = vga_pkg::BG_COLOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_bin_valid,
  input  logic [MAG_WIDTH-1:0]  i_bin_mag,
  output logic                  o_bin_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr_wr,
  output logic [DATA_WIDTH-1:0] o_data_wr,
  output logic                  o_busy,
  output logic                  o_done
);
  import vga_pkg::*;

  localparam int YW = $clog2(FB_HEIGHT);
  localparam int CW = $clog2(BAR_WIDTH);
  localparam int BW = $clog2(NUM_BINS);
  localparam int SW = H_W + 1;

  fb_state_e       r_state, w_state_nxt;
  logic [BW-1:0]   r_bin;
  logic [H_W-1:0]  r_h, w_h_nxt;
  logic            r_we;
  logic [DATA_WIDTH-1:0] r_data;
  logic            w_hs, w_clear, w_adv, w_draw_nxt;
  logic [YW-1:0]   w_y_nxt;
  logic [CW-1:0]   w_col_nxt;
  logic            w_y_last, w_col_last;

  function automatic logic [H_W-1:0] clip_height(input logic [MAG_WIDTH-1:0] mag);
    logic [MAG_WIDTH-1:0] s;
    s = mag >> MAG_SHIFT;
    if (s >= MAG_WIDTH'(FB_HEIGHT)) return H_W'(FB_HEIGHT);
    return H_W'(s);
  endfunction

  // y >= FB_HEIGHT-h rewritten as y+h >= FB_HEIGHT to avoid an underflow path.
  function automatic logic [DATA_WIDTH-1:0] pixel_color(input logic [YW-1:0] y,
                                                        input logic [CW-1:0] col,
                                                        input logic [H_W-1:0] h);
    logic [SW-1:0] sum;
    sum = SW'(y) + SW'(h);
    if ((sum >= SW'(FB_HEIGHT)) && (col != CW'(BAR_WIDTH - 1))) return BAR_COLOR;
    return BG_COLOR;
  endfunction

  assign w_hs       = (r_state == ST_FETCH) && i_bin_valid;
  assign w_clear    = (r_state == ST_IDLE) && i_start;
  assign w_adv      = (r_state == ST_DRAW);
  assign w_h_nxt    = w_hs ? clip_height(i_bin_mag) : r_h;
  assign w_draw_nxt = (w_state_nxt == ST_DRAW);

  fb_column_addr_gen #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .BAR_WIDTH (BAR_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_load_col(w_hs),
    .i_advance (w_adv),
    .o_y_nxt   (w_y_nxt),
    .o_col_nxt (w_col_nxt),
    .o_addr    (o_addr_wr),
    .o_y_last  (w_y_last),
    .o_col_last(w_col_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    o_bin_ready = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        o_bin_ready = 1'b1;
        o_busy      = 1'b1;
        if (i_bin_valid) w_state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        o_busy = 1'b1;
        if (w_y_last && w_col_last)
          w_state_nxt = (r_bin == BW'(NUM_BINS - 1)) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Write port is registered from the counters' next values, so the first
  // pixel leaves on the edge that completes the magnitude handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_h     <= '0;
      r_we    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_we    <= w_draw_nxt;
      r_data  <= w_draw_nxt ? pixel_color(w_y_nxt, w_col_nxt, w_h_nxt) : BG_COLOR;
      if (w_clear)
        r_bin <= '0;
      else if (w_adv && (w_state_nxt == ST_FETCH))
        r_bin <= r_bin + 1'b1;
    end
  end

  assign o_we      = r_we;
  assign o_data_wr = r_data;
endmodule

// File: tb/tb_spectrum_fb_writer.sv
// Bench for spectrum_fb_writer on a reduced 40x120 buffer with 8 bars:
// expected pixel writes are queued per accepted bin and checked in order.
module tb_spectrum_fb_writer;
  localparam int FBW  = 40;
  localparam int FBH  = 120;
  localparam int NB   = 8;
  localparam int BWD  = 5;
  localparam int AW   = 17;
  localparam int DW   = 12;
  localparam int MW   = 16;
  localparam int MS   = 4;
  localparam int NPIX = FBW * FBH;
  localparam int BOUND = 3 * FBH * BWD;
  localparam logic [DW-1:0] BAR = 12'h0F0;
  localparam logic [DW-1:0] BG  = 12'h000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_bin_valid = 1'b0;
  logic [MW-1:0] i_bin_mag = '0;
  logic          o_bin_ready, o_we, o_busy, o_done;
  logic [AW-1:0] o_addr_wr;
  logic [DW-1:0] o_data_wr;

  always #5 clk = ~clk;

  spectrum_fb_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_WIDTH(FBW), .FB_HEIGHT(FBH),
    .NUM_BINS(NB), .BAR_WIDTH(BWD), .MAG_WIDTH(MW), .MAG_SHIFT(MS),
    .BAR_COLOR(BAR), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_bin_valid(i_bin_valid),
    .i_bin_mag(i_bin_mag), .o_bin_ready(o_bin_ready), .o_we(o_we),
    .o_addr_wr(o_addr_wr), .o_data_wr(o_data_wr), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_writes = 0;
  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [AW-1:0] order_q[$];
  logic [DW-1:0] img [NPIX];
  logic [MW-1:0] mags [NB];

  function automatic int model_h(input logic [MW-1:0] mag);
    int s;
    s = int'(mag >> MS);
    return (s > FBH) ? FBH : s;
  endfunction

  task automatic push_bar(input int b, input logic [MW-1:0] mag);
    int  h;
    wr_t w;
    h = model_h(mag);
    for (int c = 0; c < BWD; c++)
      for (int y = 0; y < FBH; y++) begin
        w.addr = AW'(y * FBW + b * BWD + c);
        w.data = ((c != BWD - 1) && (y >= FBH - h)) ? BAR : BG;
        exp_q.push_back(w);
      end
  endtask

  task automatic fill_img();
    for (int i = 0; i < NPIX; i++) img[i] = 12'hFFF;
  endtask

  // Scoreboard: every write must be the next expected pixel.
  always @(negedge clk) begin
    if (!rst && o_we) begin
      n_writes++;
      if (int'(o_addr_wr) < NPIX) img[int'(o_addr_wr)] = o_data_wr;
      order_q.push_back(o_addr_wr);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", o_addr_wr, o_data_wr);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_addr_wr !== mon_e.addr || o_data_wr !== mon_e.data) begin
          n_fail++;
          $display("FAIL scoreboard_write: got addr %0d data %h, required addr %0d data %h",
                   o_addr_wr, o_data_wr, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic run_frame(input int stall_bin, input int restart_bin,
                           output int writes, output int busy_low, output int stall_bad,
                           output logic resume_we, output logic done_seen);
    int w0, cyc;
    bit to;
    w0 = n_writes; busy_low = 0; stall_bad = 0; resume_we = 1'b0; done_seen = 1'b0; to = 0;
    order_q.delete();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    for (int b = 0; b < NB && !to; b++) begin
      i_bin_mag   = mags[b];
      i_bin_valid = (b != stall_bin);
      cyc = 0;
      while (!o_bin_ready && cyc < BOUND) begin
        @(negedge clk); cyc++;
        if (!o_busy) busy_low++;
      end
      if (!o_bin_ready) to = 1;
      else begin
        if (b == stall_bin) begin
          repeat (10) begin
            @(negedge clk);
            if (o_we || !o_bin_ready) stall_bad++;
          end
          i_bin_valid = 1'b1;
        end
        push_bar(b, mags[b]);
        @(negedge clk);
        if (b == stall_bin) resume_we = o_we;
        if (b == restart_bin) begin
          i_start = 1'b1; @(negedge clk); i_start = 1'b0;
        end
      end
    end
    if (!to) begin
      cyc = 0;
      while (!o_done && cyc < BOUND) begin
        @(negedge clk); cyc++;
        if (!o_done && !o_busy) busy_low++;
      end
      done_seen = o_done;
    end
    i_bin_valid = 1'b0;
    writes = n_writes - w0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, required 0", o_we); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
    n_checks++; if (o_bin_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", o_bin_ready); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", o_done); end
    n_checks++; if (o_addr_wr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", o_addr_wr); end
    n_checks++; if (o_data_wr !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 000", o_data_wr); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0 || o_bin_ready !== 1'b0) begin n_fail++;
      $display("FAIL idle_after_reset: got busy %b ready %b, required 0 0", o_busy, o_bin_ready); end
  endtask

  task automatic test_all_zero();
    int   writes, busy_low, stall_bad, bad, nonbg;
    logic resume_we, done_seen;
    bit   seen [NPIX];
    for (int b = 0; b < NB; b++) mags[b] = '0;
    fill_img();
    run_frame(-1, -1, writes, busy_low, stall_bad, resume_we, done_seen);
    n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b, required 1", done_seen); end
    n_checks++; if (writes != NPIX) begin n_fail++; $display("FAIL zero_write_count: got %0d, required %0d", writes, NPIX); end
    n_checks++; if (busy_low != 0) begin n_fail++; $display("FAIL zero_busy: got %0d low cycles, required 0", busy_low); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL zero_pending: got %0d, required 0", exp_q.size()); end
    bad = 0;
    foreach (order_q[i]) begin
      if (int'(order_q[i]) >= NPIX) bad++;
      else if (seen[int'(order_q[i])]) bad++;
      else seen[int'(order_q[i])] = 1'b1;
    end
    for (int i = 0; i < NPIX; i++) if (!seen[i]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL zero_addr_cover: got %0d bad addresses, required 0", bad); end
    nonbg = 0;
    for (int i = 0; i < NPIX; i++) if (img[i] !== BG) nonbg++;
    n_checks++; if (nonbg != 0) begin n_fail++; $display("FAIL zero_all_bg: got %0d non-bg pixels, required 0", nonbg); end
    @(negedge clk);
    n_checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin n_fail++;
      $display("FAIL zero_done_pulse: got done %b busy %b, required 0 0", o_done, o_busy); end
    exp_q.delete();
  endtask

  task automatic test_bar_shape();
    int   writes, busy_low, stall_bad, bad;
    logic resume_we, done_seen;
    mags[0] = 16'h0640; mags[1] = 16'hFFFF; mags[2] = 16'h0780; mags[3] = 16'h0770;
    mags[4] = 16'h000F; mags[5] = 16'h0010;
    mags[6] = MW'($urandom_range(0, 16'h0900)); mags[7] = MW'($urandom_range(0, 16'h0900));
    fill_img();
    run_frame(-1, -1, writes, busy_low, stall_bad, resume_we, done_seen);
    n_checks++; if (done_seen !== 1'b1 || writes != NPIX) begin n_fail++;
      $display("FAIL shape_frame: got done %b writes %0d, required 1 %0d", done_seen, writes, NPIX); end
    n_checks++; if (img[19 * FBW] !== BG) begin n_fail++; $display("FAIL shape_b0_y19: got %h, required %h", img[19 * FBW], BG); end
    n_checks++; if (img[20 * FBW] !== BAR) begin n_fail++; $display("FAIL shape_b0_y20: got %h, required %h", img[20 * FBW], BAR); end
    n_checks++; if (img[(FBH - 1) * FBW] !== BAR) begin n_fail++; $display("FAIL shape_b0_bottom: got %h, required %h", img[(FBH - 1) * FBW], BAR); end
    bad = 0;
    for (int y = 0; y < FBH; y++) begin
      if (img[y * FBW + 4] !== BG) bad++;
      if (img[y * FBW + 9] !== BG) bad++;
      for (int c = 5; c < 9; c++) if (img[y * FBW + c] !== BAR) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL shape_clip_gap: got %0d wrong pixels, required 0", bad); end
    n_checks++; if (img[15] !== BG || img[FBW + 15] !== BAR) begin n_fail++;
      $display("FAIL shape_h119: got %h %h, required %h %h", img[15], img[FBW + 15], BG, BAR); end
    n_checks++; if (img[118 * FBW + 25] !== BG || img[119 * FBW + 25] !== BAR || img[119 * FBW + 20] !== BG) begin n_fail++;
      $display("FAIL shape_h1_h0: got %h %h %h, required %h %h %h", img[118 * FBW + 25], img[119 * FBW + 25],
               img[119 * FBW + 20], BG, BAR, BG); end
    n_checks++; if (order_q[0] !== AW'(0) || order_q[1] !== AW'(FBW) || order_q[FBH - 1] !== AW'((FBH - 1) * FBW)
                    || order_q[FBH] !== AW'(1)) begin n_fail++;
      $display("FAIL shape_addr_seq: got %0d %0d %0d %0d, required 0 %0d %0d 1", order_q[0], order_q[1],
               order_q[FBH - 1], order_q[FBH], FBW, (FBH - 1) * FBW); end
    n_checks++; if (order_q[order_q.size() - 1] !== AW'(NPIX - 1)) begin n_fail++;
      $display("FAIL shape_last_addr: got %0d, required %0d", order_q[order_q.size() - 1], NPIX - 1); end
    exp_q.delete();
  endtask

  task automatic test_stall_restart();
    int   writes, busy_low, stall_bad;
    logic resume_we, done_seen;
    for (int b = 0; b < NB; b++) mags[b] = MW'($urandom_range(0, 16'h0900));
    run_frame(2, 3, writes, busy_low, stall_bad, resume_we, done_seen);
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_no_write: got %0d bad cycles, required 0", stall_bad); end
    n_checks++; if (resume_we !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got we %b, required 1", resume_we); end
    n_checks++; if (done_seen !== 1'b1 || writes != NPIX) begin n_fail++;
      $display("FAIL restart_ignored: got done %b writes %0d, required 1 %0d", done_seen, writes, NPIX); end
    n_checks++; if (busy_low != 0) begin n_fail++; $display("FAIL stall_busy: got %0d low cycles, required 0", busy_low); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int   writes, busy_low, stall_bad;
    logic resume_we, done_seen;
    for (int b = 0; b < NB; b++) mags[b] = MW'($urandom_range(0, 16'h0FFF));
    run_frame(-1, -1, writes, busy_low, stall_bad, resume_we, done_seen);
    n_checks++; if (done_seen !== 1'b1 || writes != NPIX) begin n_fail++;
      $display("FAIL b2b_first: got done %b writes %0d, required 1 %0d", done_seen, writes, NPIX); end
    for (int b = 0; b < NB; b++) mags[b] = MW'($urandom_range(0, 16'h0FFF));
    run_frame(-1, -1, writes, busy_low, stall_bad, resume_we, done_seen);
    n_checks++; if (done_seen !== 1'b1 || writes != NPIX) begin n_fail++;
      $display("FAIL b2b_second: got done %b writes %0d, required 1 %0d", done_seen, writes, NPIX); end
    n_checks++; if (order_q.size() == 0 || order_q[0] !== AW'(0)) begin n_fail++;
      $display("FAIL b2b_first_addr: got %0d entries, first required 0", order_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int   w0, cyc, wr_after, writes, busy_low, stall_bad;
    logic resume_we, done_seen;
    w0 = n_writes;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    i_bin_mag = 16'h0640; i_bin_valid = 1'b1;
    n_checks++; if (o_bin_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b, required 1", o_bin_ready); end
    push_bar(0, 16'h0640);
    cyc = 0;
    while ((n_writes - w0) < 500 && cyc < BOUND) begin @(negedge clk); cyc++; end
    n_checks++; if ((n_writes - w0) < 500) begin n_fail++; $display("FAIL mid_progress: got %0d writes, required 500", n_writes - w0); end
    rst = 1'b1;
    #1;
    n_checks++; if (o_we !== 1'b0 || o_busy !== 1'b0 || o_bin_ready !== 1'b0) begin n_fail++;
      $display("FAIL mid_reset_outputs: got we %b busy %b ready %b, required 0 0 0", o_we, o_busy, o_bin_ready); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_after = n_writes;
    repeat (50) @(negedge clk);
    n_checks++; if (n_writes != wr_after) begin n_fail++;
      $display("FAIL mid_no_write: got %0d writes, required 0", n_writes - wr_after); end
    i_bin_valid = 1'b0;
    for (int b = 0; b < NB; b++) mags[b] = MW'($urandom_range(0, 16'h0900));
    run_frame(-1, -1, writes, busy_low, stall_bad, resume_we, done_seen);
    n_checks++; if (done_seen !== 1'b1 || writes != NPIX || order_q[0] !== AW'(0)) begin n_fail++;
      $display("FAIL mid_recover: got done %b writes %0d, required 1 %0d", done_seen, writes, NPIX); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_bar_shape();
    test_stall_restart();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spectrum_fb_writer.md
Name: spectrum_fb_writer

Overview:
- Renders one frame of FFT magnitude bars into the 320x240, 12-bit RGB frame buffer (linear address = y*320 + x) that the VGA scan-out reads at 2x pixel replication.
- Consumes bin magnitudes over a valid/ready stream and drives the buffer's write port, one pixel per clock.
- Sits between the FFT magnitude stage and the frame-buffer BRAM write port; started once per frame by the control logic.

Parameters:
- ADDR_WIDTH, 17, frame-buffer address width
- DATA_WIDTH, 12, pixel width, RGB 4:4:4 as {R[11:8],G[7:4],B[3:0]}
- FB_WIDTH, 320, buffer columns
- FB_HEIGHT, 240, buffer rows
- NUM_BINS, 64, bars per frame; NUM_BINS*BAR_WIDTH must equal FB_WIDTH
- BAR_WIDTH, 5, columns per bar; the last column of each bar is a background gap column
- MAG_WIDTH, 16, magnitude input width
- MAG_SHIFT, 4, right shift applied to magnitude before clipping
- BAR_COLOR, 12'h0F0, bar pixel colour
- BG_COLOR, 12'h000, background and gap colour

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  single-cycle pulse; begins frame render
- i_bin_valid  in  1  magnitude valid
- i_bin_mag  in  MAG_WIDTH  bin magnitude, bin 0 first
- o_bin_ready  out  1  block accepts a magnitude this cycle
- o_we  out  1  write enable
- o_addr_wr  out  ADDR_WIDTH  write address
- o_data_wr  out  DATA_WIDTH  write pixel
- o_busy  out  1  high from accepted start until done
- o_done  out  1  single-cycle pulse after last pixel of the frame

Behaviour:
- Reset: state IDLE; o_we=0, o_addr_wr=0, o_data_wr=0, o_bin_ready=0, o_busy=0, o_done=0; all counters cleared. Reset mid-frame abandons the frame with no further writes; the partial frame stays in the buffer.
- States: IDLE, FETCH, DRAW, DONE.
- IDLE:
  - i_start=1 -> FETCH, o_busy=1 from the next cycle, bin=0, x=0.
  - i_start while not IDLE is ignored.
- FETCH:
  - o_bin_ready=1 (combinational from state).
  - On i_bin_valid & o_bin_ready: latch h = min(i_bin_mag >> MAG_SHIFT, FB_HEIGHT) as a 9-bit value, then go to DRAW with col=0, y=0.
  - Stays in FETCH while valid=0 with no writes.
- DRAW:
  - One registered write per clock: o_we=1.
  - o_addr_wr = y*FB_WIDTH + x, maintained as a running sum: +FB_WIDTH per row; at column change reset to the new x. No multiplier.
  - o_data_wr = BAR_COLOR if (y >= FB_HEIGHT-h) and (col != BAR_WIDTH-1), else BG_COLOR.
  - Scan order is column-major: y runs 0..FB_HEIGHT-1, then col/x advance.
  - After col=BAR_WIDTH-1, y=FB_HEIGHT-1:
    - if bin<NUM_BINS-1: bin++ and go to FETCH;
    - else go to DONE.
  - Cost is FB_HEIGHT*BAR_WIDTH = 1200 write cycles per bar.
- DONE: o_done=1 for one cycle, o_busy drops on the same cycle, -> IDLE.
- Latency:
  - First write appears on o_we the cycle after the FETCH handshake.
  - The cycle after the last write of a bar is FETCH (o_we=0).
- Boundary values:
  - h=0 gives an all-background bar.
  - Any mag >= FB_HEIGHT<<MAG_SHIFT clips to a full-height bar (gap column still background).
  - The final address of a frame is FB_WIDTH*FB_HEIGHT-1 = 76799; never exceeded.
- o_we is low in every state except DRAW.

Decomposition:
- Shared package (vga_pkg): FB_WIDTH, FB_HEIGHT, DEPTH, ADDR_WIDTH, DATA_WIDTH, colour constants, and the state encoding. The VGA scan-out uses the same package.
- One natural sub-module: fb_column_addr_gen, holding the x/y counters and the running address (reset/advance/load-column inputs; y_last and col_last flags). The FSM and colour select stay in the top.

Test Plan:
- Reset asserted mid-DRAW (after 500 writes) -> same/next edge: o_we=0, o_busy=0, o_bin_ready=0; no write after deassert until the next i_start.
- Start; all 64 magnitudes=0, valid always high -> exactly 76800 writes, all BG_COLOR, addresses cover 0..76799 each once; one o_done pulse; o_busy high throughout.
- Bin0 mag=16'h0640 (>>4 = 100) -> column x=0: rows 0..139 BG, rows 140..239 BAR_COLOR (y=140 at addr 44800); x=4 all BG (gap); addr sequence 0,320,...,76480 then 1.
- Bin mag=16'hFFFF -> clipped to 240: columns 0..3 of that bar all BAR_COLOR, column 4 all BG.
- i_bin_valid held low 10 cycles in FETCH, then high -> o_we stays 0 for those cycles; writes resume one cycle after the handshake; second i_start pulse during DRAW ignored (total writes still 76800).
- Back-to-back frames: i_start the cycle after o_done -> second frame begins, bin counter restarts at 0, first write addr 0.
